// File: rtl/leaf_uplink.sv
// rtl/leaf_uplink.sv - leaf-to-spine uplink: credit-based TX FIFO/FSM and RX FIFO with drop counting
// Optional destination check on RX flits is enabled by defining LEAF_UPLINK_DEST_CHECK_EN.
module leaf_uplink #(
  parameter logic [3:0] GROUP_ID   = 4'b0110,
  parameter logic [1:0] LEAF_ID    = 2'd0,
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] up_data,
  output logic              up_valid,
  input  logic              credit_ret,
  input  logic [DWIDTH-1:0] dn_data,
  input  logic              dn_valid,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        misroute_cnt,
  output logic              credit_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Pointers wrap at FIFO_DEPTH so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------- TX path
  logic [DWIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wr_ptr;
  logic [AW-1:0]     tx_rd_ptr;
  logic [CW-1:0]     tx_count;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;

  logic [CW-1:0]     credits;
  logic              have_credit;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    NOCRED
  } tx_state_t;

  tx_state_t state;
  tx_state_t state_nxt;

  assign tx_full     = (tx_count == FULL_CNT);
  assign tx_empty    = (tx_count == '0);
  assign tx_ready    = !tx_full;
  assign tx_push     = tx_valid && !tx_full;
  assign have_credit = (credits != '0);

  // TX storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= tx_data;
    end
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= ptr_inc(tx_wr_ptr);
      end
      if (tx_pop) begin
        tx_rd_ptr <= ptr_inc(tx_rd_ptr);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // TX FSM next state and pop decision; IDLE pops on its way into SEND so
  // a lone flit leaves one cycle after it was written.
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          if (have_credit) begin
            tx_pop    = 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = NOCRED;
          end
        end
      end
      SEND: begin
        if (tx_empty) begin
          state_nxt = IDLE;
        end else if (!have_credit) begin
          state_nxt = NOCRED;
        end else begin
          tx_pop = 1'b1;
        end
      end
      NOCRED: begin
        if (have_credit) begin
          state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered uplink output: valid only in cycles following a pop, data holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_valid <= 1'b0;
      up_data  <= '0;
    end else begin
      up_valid <= tx_pop;
      if (tx_pop) begin
        up_data <= tx_mem[tx_rd_ptr];
      end
    end
  end

  // Credit counter; a send and a return in the same cycle cancel out, and a
  // return with no room left is ignored but flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits    <= FULL_CNT;
      credit_err <= 1'b0;
    end else begin
      case ({tx_pop, credit_ret})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == FULL_CNT) begin
            credit_err <= 1'b1;
          end else begin
            credits <= credits + 1'b1;
          end
        end
        default: credits <= credits;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [DWIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     rx_wr_ptr;
  logic [AW-1:0]     rx_rd_ptr;
  logic [CW-1:0]     rx_count;
  logic              rx_full;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_accept;
  logic              rx_drop;
  logic              dest_ok;

`ifdef LEAF_UPLINK_DEST_CHECK_EN
  logic [7:0] misroute_q;

  assign dest_ok = (dn_data[15:12] == GROUP_ID) && (dn_data[11:10] == LEAF_ID);

  // Saturating count of flits addressed to another group or leaf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misroute_q <= 8'd0;
    end else if (dn_valid && !dest_ok && (misroute_q != 8'hFF)) begin
      misroute_q <= misroute_q + 8'd1;
    end
  end

  assign misroute_cnt = misroute_q;
`else
  assign dest_ok      = 1'b1;
  assign misroute_cnt = 8'd0;
`endif

  assign rx_full   = (rx_count == FULL_CNT);
  assign rx_valid  = (rx_count != '0);
  assign rx_data   = rx_mem[rx_rd_ptr];
  assign rx_pop    = rx_valid && rx_ready;
  assign rx_accept = dn_valid && dest_ok;
  // A full FIFO still takes the flit when the consumer frees a slot in the same cycle.
  assign rx_push   = rx_accept && (!rx_full || rx_ready);
  assign rx_drop   = rx_accept && rx_full && !rx_ready;

  // RX storage.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= dn_data;
    end
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= ptr_inc(rx_wr_ptr);
      end
      if (rx_pop) begin
        rx_rd_ptr <= ptr_inc(rx_rd_ptr);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Saturating count of flits lost to a full RX FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (rx_drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_leaf_uplink.sv
// tb/tb_leaf_uplink.sv - directed self-checking bench for leaf_uplink
module tb_leaf_uplink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] up_data;
  logic        up_valid;
  logic        credit_ret = 1'b0;
  logic [15:0] dn_data = '0;
  logic        dn_valid = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  drop_cnt;
  logic [7:0]  misroute_cnt;
  logic        credit_err;

  int n_checks = 0;
  int n_fails  = 0;

  leaf_uplink #(
    .GROUP_ID  (4'b0110),
    .LEAF_ID   (2'd0),
    .DWIDTH    (16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .up_data     (up_data),
    .up_valid    (up_valid),
    .credit_ret  (credit_ret),
    .dn_data     (dn_data),
    .dn_valid    (dn_valid),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .drop_cnt    (drop_cnt),
    .misroute_cnt(misroute_cnt),
    .credit_err  (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    credit_ret = 1'b0;
    dn_valid   = 1'b0;
    dn_data    = '0;
    rx_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent;
    int first;
    int last;
    int n;

    // Reset state
    #1 reset = 1'b1;
    tick();
    tick();
    check("rst_up_valid", up_valid, 0);
    check("rst_up_data", up_data, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_misroute_cnt", misroute_cnt, 0);
    check("rst_credit_err", credit_err, 0);
    check("rst_credits", dut.credits, 8);
    reset = 1'b0;

    // Single flit: written on the first edge after reset, out one cycle later
    tx_valid = 1'b1;
    tx_data  = 16'h6123;
    tick();
    tx_valid = 1'b0;
    check("s1_no_bypass", up_valid, 0);
    tick();
    check("s1_up_valid", up_valid, 1);
    check("s1_up_data", up_data, 16'h6123);
    check("s1_credits", dut.credits, 7);
    tick();
    check("s1_up_valid_drop", up_valid, 0);
    check("s1_up_data_hold", up_data, 16'h6123);

    // Ten back-to-back flits with no credit returns: eight go out
    apply_reset();
    sent  = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 14; i++) begin
      tx_valid = (i < 10);
      tx_data  = 16'(16'h6000 + i);
      tick();
      if (up_valid) begin
        check("s2_data", up_data, 32'(16'h6000 + sent));
        sent++;
        if (first < 0) first = i;
        last = i;
      end
    end
    tx_valid = 1'b0;
    check("s2_sent", sent, 8);
    check("s2_consecutive", last - first, 7);
    check("s2_credits_zero", dut.credits, 0);
    check("s2_up_valid_idle", up_valid, 0);
    check("s2_tx_ready", tx_ready, 1);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (up_valid) begin
        check("s2_extra_data", up_data, 16'h6008);
        n++;
      end
    end
    check("s2_extra_count", n, 1);

    // Credit return coinciding with a send at credits=3, then overflow of credits
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      tx_valid   = (i < 6);
      tx_data    = 16'(16'h6100 + i);
      credit_ret = (i == 6);
      tick();
    end
    tx_valid   = 1'b0;
    credit_ret = 1'b0;
    check("s3_send_valid", up_valid, 1);
    check("s3_send_data", up_data, 16'h6105);
    check("s3_credits_same", dut.credits, 3);
    credit_ret = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("s3_credits_full", dut.credits, 8);
    check("s3_no_err_yet", credit_err, 0);
    tick();
    credit_ret = 1'b0;
    check("s3_credit_err", credit_err, 1);
    check("s3_credits_cap", dut.credits, 8);
    tick();
    tick();
    tick();
    check("s3_credit_err_sticky", credit_err, 1);

    // RX overflow with no consumer
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      dn_valid = 1'b1;
      dn_data  = 16'(16'h6000 + i);
      tick();
      if (i == 0) check("s4_rx_valid_rise", rx_valid, 1);
    end
    dn_valid = 1'b0;
    check("s4_drop_cnt", drop_cnt, 2);
    for (int i = 0; i < 8; i++) begin
      rx_ready = 1'b1;
      check("s4_rx_data", rx_data, 32'(16'h6000 + i));
      tick();
    end
    rx_ready = 1'b0;
    check("s4_rx_empty", rx_valid, 0);
    check("s4_drop_hold", drop_cnt, 2);

    // RX full but consumer ready on the ninth beat
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      dn_valid = 1'b1;
      dn_data  = 16'(16'h6000 + i);
      rx_ready = (i == 8);
      tick();
    end
    dn_valid = 1'b0;
    rx_ready = 1'b0;
    check("s4b_drop_cnt", drop_cnt, 1);
    check("s4b_rx_head", rx_data, 16'h6001);

    // Destination check
    apply_reset();
    dn_valid = 1'b1;
    dn_data  = 16'h7000;
    tick();
    dn_valid = 1'b0;
`ifdef LEAF_UPLINK_DEST_CHECK_EN
    check("s5_misroute_not_buffered", rx_valid, 0);
    check("s5_misroute_cnt", misroute_cnt, 1);
    check("s5_misroute_no_drop", drop_cnt, 0);
    dn_valid = 1'b1;
    dn_data  = 16'h6000;
    tick();
    dn_valid = 1'b0;
    check("s5_local_rx_valid", rx_valid, 1);
    check("s5_local_rx_data", rx_data, 16'h6000);
    check("s5_misroute_hold", misroute_cnt, 1);
`else
    check("s5_accept_rx_valid", rx_valid, 1);
    check("s5_accept_rx_data", rx_data, 16'h7000);
    check("s5_misroute_zero", misroute_cnt, 0);
`endif

    // Reset with five flits held in each FIFO
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      tx_valid   = (i < 13);
      tx_data    = 16'(16'h6200 + i);
      dn_valid   = (i < 5);
      dn_data    = 16'(16'h6300 + i);
      credit_ret = (i == 0);
      tick();
    end
    tx_valid   = 1'b0;
    dn_valid   = 1'b0;
    credit_ret = 1'b0;
    check("s6_pre_credit_err", credit_err, 1);
    check("s6_pre_rx_valid", rx_valid, 1);
    check("s6_pre_up_data", up_data, 16'h6207);
    reset = 1'b1;
    #1;
    check("s6_tx_ready", tx_ready, 1);
    check("s6_rx_valid", rx_valid, 0);
    check("s6_up_valid", up_valid, 0);
    check("s6_up_data", up_data, 0);
    check("s6_drop_cnt", drop_cnt, 0);
    check("s6_misroute_cnt", misroute_cnt, 0);
    check("s6_credit_err", credit_err, 0);
    check("s6_credits", dut.credits, 8);
    tick();
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 16'h6abc;
    dn_valid = 1'b1;
    dn_data  = 16'h6def;
    tick();
    tx_valid = 1'b0;
    dn_valid = 1'b0;
    check("s6_resume_rx_valid", rx_valid, 1);
    check("s6_resume_rx_data", rx_data, 16'h6def);
    tick();
    check("s6_resume_up_valid", up_valid, 1);
    check("s6_resume_up_data", up_data, 16'h6abc);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (up_valid) n++;
    end
    check("s6_no_stale_tx", n, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("s6_no_stale_rx", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
